// File: rtl/sd_xfer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_xfer_sched_pkg
// Description : Shared types and helpers for the SD transfer scheduler:
//               FSM state encoding, interrupt event bundle, and
//               Present State inhibit decode.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_xfer_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CMD_ISSUE  = 3'd1,
    ST_CMD_WAIT   = 3'd2,
    ST_XFER_START = 3'd3,
    ST_XFER_RUN   = 3'd4,
    ST_GAP_STOP   = 3'd5
  } state_e;

  // One-cycle interrupt event pulses (NISR bits 0..2 plus the error summary)
  typedef struct packed {
    logic cmd_done;
    logic xfer_done;
    logic gap;
    logic err;
  } evt_t;

  // PSR bit 0: the CMD line is owned by the current command
  function automatic logic cmd_phase(input state_e s);
    return (s == ST_CMD_ISSUE) || (s == ST_CMD_WAIT);
  endfunction

  // PSR bit 1: the DAT lines are owned; a data command claims them while
  // still waiting for its response
  function automatic logic dat_phase(input state_e s, input logic dp);
    return ((s == ST_CMD_WAIT) && dp) || (s == ST_XFER_START) ||
           (s == ST_XFER_RUN) || (s == ST_GAP_STOP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_xfer_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_xfer_sched_if
// Description : Request/handshake bundle between the register bank, the
//               CMD/DAT/DMA blocks and the transfer scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_xfer_sched_if #(
  parameter int BLK_CNT_W = 16
);
  // Requests and completions toward the scheduler
  logic                 new_cmd;
  logic                 data_present;
  logic                 multi_block;
  logic                 blk_cnt_en;
  logic [BLK_CNT_W-1:0] block_count;
  logic                 stop_at_gap;
  logic                 continue_req;
  logic                 cmd_complete;
  logic                 cmd_timeout;
  logic                 dat_block_done;
  logic                 dat_error;
  // Scheduler results
  logic                 cmd_start;
  logic                 xfer_start;
  logic                 dat_active;
  logic                 cmd_inhibit;
  logic                 dat_inhibit;
  logic [BLK_CNT_W-1:0] blocks_left;
  logic                 cmd_done_evt;
  logic                 xfer_done_evt;
  logic                 gap_evt;
  logic                 err_evt;

  modport master (
    output new_cmd, data_present, multi_block, blk_cnt_en, block_count,
           stop_at_gap, continue_req, cmd_complete, cmd_timeout,
           dat_block_done, dat_error,
    input  cmd_start, xfer_start, dat_active, cmd_inhibit, dat_inhibit,
           blocks_left, cmd_done_evt, xfer_done_evt, gap_evt, err_evt
  );

  modport slave (
    input  new_cmd, data_present, multi_block, blk_cnt_en, block_count,
           stop_at_gap, continue_req, cmd_complete, cmd_timeout,
           dat_block_done, dat_error,
    output cmd_start, xfer_start, dat_active, cmd_inhibit, dat_inhibit,
           blocks_left, cmd_done_evt, xfer_done_evt, gap_evt, err_evt
  );
endinterface
`default_nettype wire

// File: rtl/sd_blk_counter.sv
`default_nettype none
// ============================================================================
// Module      : sd_blk_counter
// Description : Loadable block down-counter with decrement enable, zero
//               flag and a freeze (unlimited-transfer) mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_blk_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         freeze_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o,
  output logic         frozen_o
);

  logic [W-1:0] count_q, count_d;
  logic         frozen_q, frozen_d;

  // Load wins over decrement; decrement stops at zero and is ignored when frozen
  always_comb begin
    count_d  = count_q;
    frozen_d = frozen_q;
    if (load_i) begin
      count_d  = load_val_i;
      frozen_d = freeze_i;
    end else if (dec_i && !frozen_q && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q  <= '0;
      frozen_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      frozen_q <= frozen_d;
    end
  end

  assign count_o  = count_q;
  assign zero_o   = !frozen_q && (count_q == '0);
  assign frozen_o = frozen_q;

endmodule
`default_nettype wire

// File: rtl/sd_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module      : sd_xfer_sched
// Description : SD host transfer scheduler. Issues the command, waits for
//               its response, then runs the data phase block by block with
//               block-gap stop/continue, PSR inhibits and interrupt events.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_xfer_sched
  import sd_xfer_sched_pkg::*;
#(
  parameter int BLK_CNT_W = 16
) (
  input logic             CLK,
  input logic             RESET,
  sd_xfer_sched_if.slave  bus
);

  state_e               state_q, state_d;
  logic                 dp_q, dp_d;
  evt_t                 evt_q, evt_d;
  logic                 cmd_start_q, cmd_start_d;
  logic                 xfer_start_q, xfer_start_d;
  logic                 dat_active_q;
  logic                 cmd_inh_q;
  logic                 dat_inh_q;

  logic                 accept;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic                 cnt_frozen;
  logic                 cnt_freeze;
  logic                 last_blk;
  logic [BLK_CNT_W-1:0] cnt_val;
  logic [BLK_CNT_W-1:0] cnt_load_val;

  assign accept       = (state_q == ST_IDLE) && bus.new_cmd;
  // Single-block commands always move exactly one block; an enabled block
  // count is taken as-is; otherwise the counter is frozen (unlimited)
  assign cnt_load_val = bus.multi_block ? bus.block_count : BLK_CNT_W'(1);
  assign cnt_freeze   = bus.multi_block && !bus.blk_cnt_en;
  assign last_blk     = !cnt_frozen && (cnt_val == BLK_CNT_W'(1));

  sd_blk_counter #(.W(BLK_CNT_W)) u_blk_counter (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_i     (accept),
    .load_val_i (cnt_load_val),
    .freeze_i   (cnt_freeze),
    .dec_i      (cnt_dec),
    .count_o    (cnt_val),
    .zero_o     (cnt_zero),
    .frozen_o   (cnt_frozen)
  );

  // Next-state and event decode; errors outrank completions on the same cycle
  always_comb begin
    state_d      = state_q;
    dp_d         = dp_q;
    evt_d        = '0;
    cmd_start_d  = 1'b0;
    xfer_start_d = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.new_cmd) begin
          state_d     = ST_CMD_ISSUE;
          dp_d        = bus.data_present;
          cmd_start_d = 1'b1;
        end
      end
      ST_CMD_ISSUE: state_d = ST_CMD_WAIT;
      ST_CMD_WAIT: begin
        if (bus.cmd_timeout) begin
          evt_d.err = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.cmd_complete) begin
          evt_d.cmd_done = 1'b1;
          if (dp_q && !cnt_zero) begin
            state_d = ST_XFER_START;
          end else begin
            state_d         = ST_IDLE;
            evt_d.xfer_done = dp_q;
          end
        end
      end
      ST_XFER_START: begin
        xfer_start_d = 1'b1;
        state_d      = ST_XFER_RUN;
      end
      ST_XFER_RUN: begin
        if (bus.dat_error) begin
          evt_d.err = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.dat_block_done) begin
          cnt_dec = 1'b1;
          if (last_blk) begin
            evt_d.xfer_done = 1'b1;
            state_d         = ST_IDLE;
          end else if (bus.stop_at_gap) begin
            evt_d.gap = 1'b1;
            state_d   = ST_GAP_STOP;
          end
        end
      end
      ST_GAP_STOP: begin
        if (bus.dat_error) begin
          evt_d.err = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.continue_req) begin
          state_d = ST_XFER_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; status levels follow the state being entered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      dp_q         <= 1'b0;
      evt_q        <= '0;
      cmd_start_q  <= 1'b0;
      xfer_start_q <= 1'b0;
      dat_active_q <= 1'b0;
      cmd_inh_q    <= 1'b0;
      dat_inh_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dp_q         <= dp_d;
      evt_q        <= evt_d;
      cmd_start_q  <= cmd_start_d;
      xfer_start_q <= xfer_start_d;
      dat_active_q <= (state_d == ST_XFER_RUN);
      cmd_inh_q    <= cmd_phase(state_d);
      dat_inh_q    <= dat_phase(state_d, dp_d);
    end
  end

  assign bus.cmd_start     = cmd_start_q;
  assign bus.xfer_start    = xfer_start_q;
  assign bus.dat_active    = dat_active_q;
  assign bus.cmd_inhibit   = cmd_inh_q;
  assign bus.dat_inhibit   = dat_inh_q;
  assign bus.blocks_left   = cnt_val;
  assign bus.cmd_done_evt  = evt_q.cmd_done;
  assign bus.xfer_done_evt = evt_q.xfer_done;
  assign bus.gap_evt       = evt_q.gap;
  assign bus.err_evt       = evt_q.err;

endmodule
`default_nettype wire

// File: tb/tb_sd_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_xfer_sched
// Description : Self-checking bench for sd_xfer_sched. A timeline model
//               records, per cycle, which event pulses and status levels
//               the scheduler must show; a compare process checks every
//               cycle, and literal checks pin key values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_xfer_sched;

  localparam int W    = 16;
  localparam int MAXC = 2048;

  // Event indices into the expectation timeline
  localparam int E_CS  = 0;  // cmd_start
  localparam int E_XS  = 1;  // xfer_start
  localparam int E_CD  = 2;  // cmd_done_evt
  localparam int E_XD  = 3;  // xfer_done_evt
  localparam int E_GAP = 4;  // gap_evt
  localparam int E_ERR = 5;  // err_evt

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  sd_xfer_sched_if #(.BLK_CNT_W(W)) bus ();

  sd_xfer_sched #(.BLK_CNT_W(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected timeline: event pulses, {cmd_inhibit, dat_inhibit, dat_active}, blocks_left
  bit [5:0] exp_ev [MAXC];
  bit [2:0] exp_lv [MAXC];
  int       exp_bl [MAXC];

  int  nchk   = 0;
  int  nerr   = 0;
  bit  chk_en = 1'b0;
  int  cnt_ev [6];
  int  base_ev [6];

  // Model state: blocks still owed and whether the command carries data
  int  m_left = 0;
  bit  m_dp   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic pulse_at(input int idx, input int c);
    if (c < MAXC) exp_ev[c][idx] = 1'b1;
  endtask

  task automatic levels_from(input int c, input bit ci, input bit di, input bit da, input int bl);
    for (int i = c; i < MAXC; i++) begin
      exp_lv[i] = {ci, di, da};
      exp_bl[i] = bl;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    for (int i = 0; i < 6; i++) base_ev[i] = cnt_ev[i];
  endtask

  task automatic chk_cnt(input string nm, input int idx, input int exp);
    chk(nm, cnt_ev[idx] - base_ev[idx], exp);
  endtask

  // Command written in IDLE: cmd_start next cycle, CMD phase after that
  task automatic issue_cmd(input bit dp, input bit mb, input int bc);
    int n;
    n      = cyc;
    m_dp   = dp;
    m_left = mb ? bc : 1;
    pulse_at(E_CS, n + 1);
    levels_from(n + 1, 1'b1, 1'b0, 1'b0, m_left);
    levels_from(n + 2, 1'b1, dp, 1'b0, m_left);
    bus.new_cmd      = 1'b1;
    bus.data_present = dp;
    bus.multi_block  = mb;
    bus.blk_cnt_en   = 1'b1;
    bus.block_count  = W'(bc);
    tick();
    bus.new_cmd      = 1'b0;
    bus.data_present = 1'b0;
    bus.multi_block  = 1'b0;
    bus.blk_cnt_en   = 1'b0;
    bus.block_count  = '0;
  endtask

  // new_cmd while busy: nothing about the expected timeline changes
  task automatic ignored_cmd();
    bus.new_cmd      = 1'b1;
    bus.data_present = 1'b0;
    bus.multi_block  = 1'b0;
    bus.block_count  = W'(9);
    tick();
    bus.new_cmd      = 1'b0;
    bus.block_count  = '0;
  endtask

  // Command response; a timeout wins over a simultaneous completion
  task automatic cmd_resp(input bit cc, input bit to);
    int m;
    m = cyc;
    if (to) begin
      pulse_at(E_ERR, m + 1);
      levels_from(m + 1, 1'b0, 1'b0, 1'b0, m_left);
    end else if (cc) begin
      pulse_at(E_CD, m + 1);
      if (m_dp && m_left > 0) begin
        levels_from(m + 1, 1'b0, 1'b1, 1'b0, m_left);
        pulse_at(E_XS, m + 2);
        levels_from(m + 2, 1'b0, 1'b1, 1'b1, m_left);
      end else begin
        levels_from(m + 1, 1'b0, 1'b0, 1'b0, m_left);
        if (m_dp) pulse_at(E_XD, m + 1);
      end
    end
    bus.cmd_complete = cc;
    bus.cmd_timeout  = to;
    tick();
    bus.cmd_complete = 1'b0;
    bus.cmd_timeout  = 1'b0;
  endtask

  // One block completes during the data phase, optionally with an error
  task automatic blk(input bit err);
    int k;
    k = cyc;
    if (err) begin
      pulse_at(E_ERR, k + 1);
      levels_from(k + 1, 1'b0, 1'b0, 1'b0, m_left);
    end else begin
      if (m_left > 0) m_left--;
      if (m_left == 0) begin
        pulse_at(E_XD, k + 1);
        levels_from(k + 1, 1'b0, 1'b0, 1'b0, 0);
      end else if (bus.stop_at_gap) begin
        pulse_at(E_GAP, k + 1);
        levels_from(k + 1, 1'b0, 1'b1, 1'b0, m_left);
      end else begin
        levels_from(k + 1, 1'b0, 1'b1, 1'b1, m_left);
      end
    end
    bus.dat_block_done = 1'b1;
    bus.dat_error      = err;
    tick();
    bus.dat_block_done = 1'b0;
    bus.dat_error      = 1'b0;
  endtask

  // Continue from a block gap: restart pulse two cycles later
  task automatic cont();
    int g;
    g = cyc;
    levels_from(g + 1, 1'b0, 1'b1, 1'b0, m_left);
    pulse_at(E_XS, g + 2);
    levels_from(g + 2, 1'b0, 1'b1, 1'b1, m_left);
    bus.continue_req = 1'b1;
    tick();
    bus.continue_req = 1'b0;
  endtask

  // Reset takes effect at the next edge and cancels any pending pulses
  task automatic do_reset();
    int r;
    r = cyc;
    for (int i = r + 1; i < MAXC; i++) exp_ev[i] = '0;
    levels_from(r + 1, 1'b0, 1'b0, 1'b0, 0);
    m_left = 0;
    RESET  = 1'b1;
    tick();
    RESET  = 1'b0;
  endtask

  // Per-cycle comparison against the timeline, plus event counting
  always @(negedge CLK) begin
    if (chk_en && cyc < MAXC) begin
      chk("cmd_start",     {31'd0, bus.cmd_start},     {31'd0, exp_ev[cyc][E_CS]});
      chk("xfer_start",    {31'd0, bus.xfer_start},    {31'd0, exp_ev[cyc][E_XS]});
      chk("cmd_done_evt",  {31'd0, bus.cmd_done_evt},  {31'd0, exp_ev[cyc][E_CD]});
      chk("xfer_done_evt", {31'd0, bus.xfer_done_evt}, {31'd0, exp_ev[cyc][E_XD]});
      chk("gap_evt",       {31'd0, bus.gap_evt},       {31'd0, exp_ev[cyc][E_GAP]});
      chk("err_evt",       {31'd0, bus.err_evt},       {31'd0, exp_ev[cyc][E_ERR]});
      chk("cmd_inhibit",   {31'd0, bus.cmd_inhibit},   {31'd0, exp_lv[cyc][2]});
      chk("dat_inhibit",   {31'd0, bus.dat_inhibit},   {31'd0, exp_lv[cyc][1]});
      chk("dat_active",    {31'd0, bus.dat_active},    {31'd0, exp_lv[cyc][0]});
      chk("blocks_left",   {16'd0, bus.blocks_left},   exp_bl[cyc]);
      cnt_ev[E_CS]  += int'(bus.cmd_start);
      cnt_ev[E_XS]  += int'(bus.xfer_start);
      cnt_ev[E_CD]  += int'(bus.cmd_done_evt);
      cnt_ev[E_XD]  += int'(bus.xfer_done_evt);
      cnt_ev[E_GAP] += int'(bus.gap_evt);
      cnt_ev[E_ERR] += int'(bus.err_evt);
    end
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      cnt_ev[i]  = 0;
      base_ev[i] = 0;
    end
    bus.new_cmd        = 1'b0;
    bus.data_present   = 1'b0;
    bus.multi_block    = 1'b0;
    bus.blk_cnt_en     = 1'b0;
    bus.block_count    = '0;
    bus.stop_at_gap    = 1'b0;
    bus.continue_req   = 1'b0;
    bus.cmd_complete   = 1'b0;
    bus.cmd_timeout    = 1'b0;
    bus.dat_block_done = 1'b0;
    bus.dat_error      = 1'b0;

    // Reset state
    idle(3);
    RESET  = 1'b0;
    chk_en = 1'b1;
    chk("rst_blocks_left", {16'd0, bus.blocks_left}, 32'd0);
    chk("rst_cmd_inhibit", {31'd0, bus.cmd_inhibit}, 32'd0);
    idle(2);

    // Command without data, response five cycles after new_cmd
    snap();
    issue_cmd(1'b0, 1'b0, 0);
    chk("nodata_cmd_start", {31'd0, bus.cmd_start}, 32'd1);
    idle(4);
    cmd_resp(1'b1, 1'b0);
    idle(3);
    chk_cnt("nodata_cmd_done_cnt", E_CD, 1);
    chk_cnt("nodata_xfer_start_cnt", E_XS, 0);
    chk("nodata_cmd_inhibit", {31'd0, bus.cmd_inhibit}, 32'd0);

    // Three-block transfer
    snap();
    issue_cmd(1'b1, 1'b1, 3);
    idle(2);
    cmd_resp(1'b1, 1'b0);
    idle(2);
    blk(1'b0);
    chk("mb_left_2", {16'd0, bus.blocks_left}, 32'd2);
    idle(2);
    blk(1'b0);
    chk("mb_left_1", {16'd0, bus.blocks_left}, 32'd1);
    idle(2);
    blk(1'b0);
    chk("mb_left_0", {16'd0, bus.blocks_left}, 32'd0);
    chk("mb_xfer_done_now", {31'd0, bus.xfer_done_evt}, 32'd1);
    idle(3);
    chk_cnt("mb_xfer_done_cnt", E_XD, 1);

    // Block gap after the first of four blocks, resumed by continue_req
    snap();
    issue_cmd(1'b1, 1'b1, 4);
    idle(2);
    cmd_resp(1'b1, 1'b0);
    idle(2);
    bus.stop_at_gap = 1'b1;
    blk(1'b0);
    chk("gap_evt_now", {31'd0, bus.gap_evt}, 32'd1);
    chk("gap_dat_active", {31'd0, bus.dat_active}, 32'd0);
    chk("gap_left_3", {16'd0, bus.blocks_left}, 32'd3);
    bus.stop_at_gap = 1'b0;
    idle(4);
    cont();
    idle(2);
    repeat (3) begin
      blk(1'b0);
      idle(2);
    end
    idle(1);
    chk_cnt("gap_xfer_start_cnt", E_XS, 2);
    chk_cnt("gap_xfer_done_cnt", E_XD, 1);

    // Last block with stop_at_gap held: completion only, no gap event
    snap();
    bus.stop_at_gap = 1'b1;
    issue_cmd(1'b1, 1'b1, 2);
    idle(2);
    cmd_resp(1'b1, 1'b0);
    idle(2);
    blk(1'b0);
    idle(2);
    cont();
    idle(2);
    blk(1'b0);
    bus.stop_at_gap = 1'b0;
    idle(3);
    chk_cnt("lastgap_gap_cnt", E_GAP, 1);
    chk_cnt("lastgap_done_cnt", E_XD, 1);

    // Timeout together with completion
    snap();
    issue_cmd(1'b1, 1'b1, 2);
    idle(2);
    cmd_resp(1'b1, 1'b1);
    idle(3);
    chk_cnt("to_err_cnt", E_ERR, 1);
    chk_cnt("to_cmd_done_cnt", E_CD, 0);

    // Data error together with block done at blocks_left=2
    snap();
    issue_cmd(1'b1, 1'b1, 3);
    idle(2);
    cmd_resp(1'b1, 1'b0);
    idle(2);
    blk(1'b0);
    idle(1);
    blk(1'b1);
    chk("derr_left_2", {16'd0, bus.blocks_left}, 32'd2);
    idle(3);
    chk_cnt("derr_err_cnt", E_ERR, 1);
    chk_cnt("derr_done_cnt", E_XD, 0);

    // new_cmd during the data phase is ignored
    snap();
    issue_cmd(1'b1, 1'b1, 2);
    idle(2);
    cmd_resp(1'b1, 1'b0);
    idle(2);
    ignored_cmd();
    idle(2);
    blk(1'b0);
    idle(2);
    blk(1'b0);
    idle(3);
    chk_cnt("ign_cmd_start_cnt", E_CS, 1);

    // Zero-block transfer with counting enabled
    snap();
    issue_cmd(1'b1, 1'b1, 0);
    idle(2);
    cmd_resp(1'b1, 1'b0);
    idle(3);
    chk_cnt("zero_xfer_start_cnt", E_XS, 0);
    chk_cnt("zero_xfer_done_cnt", E_XD, 1);

    // Single-block data command ignores block_count
    issue_cmd(1'b1, 1'b0, 7);
    chk("single_left_1", {16'd0, bus.blocks_left}, 32'd1);
    idle(2);
    cmd_resp(1'b1, 1'b0);
    idle(2);
    blk(1'b0);
    idle(3);

    // Reset while stopped at a block gap
    snap();
    bus.stop_at_gap = 1'b1;
    issue_cmd(1'b1, 1'b1, 3);
    idle(2);
    cmd_resp(1'b1, 1'b0);
    idle(2);
    blk(1'b0);
    idle(2);
    do_reset();
    chk("rstgap_dat_inhibit", {31'd0, bus.dat_inhibit}, 32'd0);
    chk("rstgap_blocks_left", {16'd0, bus.blocks_left}, 32'd0);
    bus.stop_at_gap = 1'b0;
    idle(4);
    chk_cnt("rstgap_err_cnt", E_ERR, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
